branch_pred_scoreboard: RTL and testbench
=========================================

Name: branch_pred_scoreboard

Overview:
Sits directly downstream of the 2-bit saturating-counter branch predictor. It snoops the predictor's request/result/taken inputs and its prediction output, and queues each issued prediction in a small in-order buffer. When the matching result arrives, it scores the prediction against the actual outcome. It keeps saturating hit/miss counters and sticky error flags for bench and accuracy reporting.

Parameters:
DEPTH, 4, maximum number of outstanding (predicted but unresolved) branches; power of two, at least 2.
CNT_W, 16, width of the hit and miss counters.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
request  input  1  same net as the predictor's request input.
result  input  1  same net as the predictor's result input.
taken  input  1  same net as the predictor's taken input; valid when result=1.
prediction  input  1  the predictor's prediction output.
hit_count  output  CNT_W  number of correct predictions scored.
miss_count  output  CNT_W  number of mispredictions scored.
pending  output  $clog2(DEPTH+1)  number of queued, unresolved predictions.
last_valid  output  1  high once any prediction has been scored since reset.
last_correct  output  1  outcome of the most recent scoring.
overflow  output  1  sticky; a prediction was dropped because the buffer was full.
underflow  output  1  sticky; a result arrived with nothing to score.

Behaviour:
- Reset (rst=1 at an edge): all outputs 0, buffer empty, capture flag cleared. Reset takes priority over every other event, including an operation in flight.
- Request acceptance mirrors the predictor: result has priority. A request counts only when request=1 and result=0 at an edge.
- Capture: an accepted request at edge N sets cap_pend. At edge N+1, prediction (updated by the predictor at edge N) is pushed into the buffer and cap_pend clears.
- Push when full (pending=DEPTH and no pop at the same edge): the value is dropped, overflow is set, and pending is unchanged.
- Push and pop at the same edge with buffer not empty: both occur; pending is unchanged.
- Scoring happens when result=1 at an edge:
  - Buffer not empty: pop the oldest entry and compare it with taken.
  - Buffer empty but cap_pend=1 (bypass): compare the incoming prediction with taken directly. Nothing is pushed and pending stays 0.
  - Buffer empty and cap_pend=0: set underflow; counters and last_* are unchanged.
- Score update: correct (entry==taken) increments hit_count, otherwise miss_count increments. Set last_valid=1 and last_correct to the compare result, all at the same edge as the pop.
- Counters saturate at all-ones and never wrap.
- pending equals the buffer occupancy after each edge. Storage is a circular buffer; read/write pointers wrap modulo DEPTH.
- No combinational path from inputs to outputs; every output is registered.
- Latency: a result is reflected in the counters in the cycle after its edge.

Decomposition:
- Shared package bp_pkg holds:
  - default CNT_W and DEPTH constants;
  - the 2-bit predictor state encoding (00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken);
  - a score_t enum (SCORE_HIT, SCORE_MISS).
- One natural sub-module: bp_score_fifo, a DEPTH x 1-bit synchronous FIFO with push, pop, full, empty and count, and simultaneous push/pop support.
- Scoring, bypass and counters stay in the top module.

Test Plan:
- Reset, then request=1 for 1 cycle; predictor outputs prediction=0; 3 cycles later result=1, taken=0 -> pending goes 1 then 0, hit_count=1, miss_count=0, last_valid=1, last_correct=1.
- DEPTH=4: 5 back-to-back accepted requests with no results -> pending=4, overflow=1 from the 5th capture edge; then 4 results -> pending=0, hit_count+miss_count=4.
- result=1 with buffer empty and no capture pending -> underflow=1; hit_count, miss_count and last_* unchanged.
- Request at edge N, result=1, taken=1 at edge N+1 (prediction=0, bypass) -> miss_count=1, pending stays 0, last_correct=0.
- request=1 and result=1 at the same edge with 1 entry queued -> request ignored, entry popped, pending=0, no later push.
- CNT_W=2: 5 consecutive hits -> hit_count=3 (saturated). Then assert rst mid-stream with 2 entries pending -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and types for the branch predictor and its scoreboard.
// Also holds the 2-bit predictor state encoding so both sides agree on it.
package bp_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        PRED_STRONG_NT = 2'b00,
        PRED_WEAK_NT   = 2'b01,
        PRED_WEAK_T    = 2'b10,
        PRED_STRONG_T  = 2'b11
    } pred_state_t;

    typedef enum logic {
        SCORE_HIT  = 1'b0,
        SCORE_MISS = 1'b1
    } score_t;

    // The predictor says "taken" in either taken state.
    function automatic logic pred_taken(input pred_state_t state);
        return state[1];
    endfunction

    function automatic score_t score_of(input logic predicted, input logic actual);
        return (predicted == actual) ? SCORE_HIT : SCORE_MISS;
    endfunction

endpackage

// File: rtl/bp_score_fifo.sv
// DEPTH x 1-bit synchronous FIFO holding predictions awaiting their result.
// Push and pop may happen together; a push into a full FIFO is only kept if a pop frees a slot.
module bp_score_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       push_data,
    input  logic                       pop,
    output logic                       pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_pred_scoreboard.sv
// Snoops the 2-bit branch predictor, queues each issued prediction in order and
// scores it against the actual outcome when the matching result arrives.
module branch_pred_scoreboard
    import bp_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       request,
    input  logic                       result,
    input  logic                       taken,
    input  logic                       prediction,
    output logic [CNT_W-1:0]           hit_count,
    output logic [CNT_W-1:0]           miss_count,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       last_valid,
    output logic                       last_correct,
    output logic                       overflow,
    output logic                       underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Handshake: a request is accepted only when result is low at the edge; the
    // predictor's answer is visible one edge later, so capture is deferred by cap_pend.
    logic   cap_pend;
    logic   accept_req;
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   bypass;
    logic   no_entry;
    logic   scored;
    logic   scored_bit;
    score_t score;

    assign accept_req = request & ~result;
    assign fifo_pop   = result & ~fifo_empty;
    assign bypass     = result & fifo_empty & cap_pend;
    assign no_entry   = result & fifo_empty & ~cap_pend;
    assign fifo_push  = cap_pend & ~bypass;
    assign scored     = fifo_pop | bypass;
    assign scored_bit = fifo_pop ? fifo_head : prediction;
    assign score      = score_of(scored_bit, taken);

    bp_score_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(prediction),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_pend     <= 1'b0;
            hit_count    <= '0;
            miss_count   <= '0;
            last_valid   <= 1'b0;
            last_correct <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            cap_pend <= accept_req;
            if (scored) begin
                last_valid   <= 1'b1;
                last_correct <= (score == SCORE_HIT);
                if (score == SCORE_HIT) begin
                    if (hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;
                end else begin
                    if (miss_count != CNT_MAX) miss_count <= miss_count + 1'b1;
                end
            end
            // A full buffer with no pop this edge loses the incoming prediction.
            if (fifo_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            if (no_entry) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic, scored against a
// queue-based model of the scoreboard rules. A second instance uses CNT_W=2 for saturation.
module tb_branch_pred_scoreboard;
    localparam int DEPTH  = 4;
    localparam int PEND_W = $clog2(DEPTH + 1);

    logic clk;
    logic rst;
    logic request;
    logic result;
    logic taken;
    logic prediction;

    logic [15:0]       hit_count;
    logic [15:0]       miss_count;
    logic [PEND_W-1:0] pending;
    logic              last_valid;
    logic              last_correct;
    logic              overflow;
    logic              underflow;

    logic [1:0]        s_hit_count;
    logic [1:0]        s_miss_count;
    logic [PEND_W-1:0] s_pending;
    logic              s_last_valid;
    logic              s_last_correct;
    logic              s_overflow;
    logic              s_underflow;

    int checks;
    int failures;

    // model state
    logic [0:0] exp_q[$];
    logic       m_cap;
    int         m_hits;
    int         m_misses;
    logic       m_lv;
    logic       m_lc;
    logic       m_ov;
    logic       m_un;

    branch_pred_scoreboard #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .request(request), .result(result),
        .taken(taken), .prediction(prediction),
        .hit_count(hit_count), .miss_count(miss_count), .pending(pending),
        .last_valid(last_valid), .last_correct(last_correct),
        .overflow(overflow), .underflow(underflow)
    );

    branch_pred_scoreboard #(.DEPTH(DEPTH), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .request(request), .result(result),
        .taken(taken), .prediction(prediction),
        .hit_count(s_hit_count), .miss_count(s_miss_count), .pending(s_pending),
        .last_valid(s_last_valid), .last_correct(s_last_correct),
        .overflow(s_overflow), .underflow(s_underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    task automatic model_edge();
        logic bypassed;
        logic entry;
        if (rst) begin
            exp_q.delete();
            m_cap = 1'b0; m_hits = 0; m_misses = 0;
            m_lv = 1'b0; m_lc = 1'b0; m_ov = 1'b0; m_un = 1'b0;
            return;
        end
        bypassed = 1'b0;
        if (result) begin
            if (exp_q.size() > 0) begin
                entry = exp_q.pop_front();
                if (entry == taken) m_hits++; else m_misses++;
                m_lv = 1'b1; m_lc = (entry == taken);
            end else if (m_cap) begin
                bypassed = 1'b1;
                if (prediction == taken) m_hits++; else m_misses++;
                m_lv = 1'b1; m_lc = (prediction == taken);
            end else begin
                m_un = 1'b1;
            end
        end
        if (m_cap && !bypassed) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(prediction);
            else m_ov = 1'b1;
        end
        m_cap = request && !result;
    endtask

    task automatic check_all();
        check("hit_count",      32'(hit_count),    32'(sat(m_hits, 65535)));
        check("miss_count",     32'(miss_count),   32'(sat(m_misses, 65535)));
        check("pending",        32'(pending),      32'(exp_q.size()));
        check("last_valid",     32'(last_valid),   32'(m_lv));
        check("last_correct",   32'(last_correct), 32'(m_lc));
        check("overflow",       32'(overflow),     32'(m_ov));
        check("underflow",      32'(underflow),    32'(m_un));
        check("sat_hit_count",  32'(s_hit_count),  32'(sat(m_hits, 3)));
        check("sat_miss_count", 32'(s_miss_count), 32'(sat(m_misses, 3)));
        check("sat_pending",    32'(s_pending),    32'(exp_q.size()));
        check("sat_overflow",   32'(s_overflow),   32'(m_ov));
        check("sat_underflow",  32'(s_underflow),  32'(m_un));
    endtask

    // driver: inputs change on the falling edge, outputs are compared on the next falling edge
    task automatic drive(input logic rst_v, input logic req_v, input logic res_v,
                         input logic tk_v, input logic pred_v);
        rst = rst_v; request = req_v; result = res_v; taken = tk_v; prediction = pred_v;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; request = 1'b0; result = 1'b0; taken = 1'b0; prediction = 1'b0;
        m_cap = 1'b0; m_hits = 0; m_misses = 0;
        m_lv = 1'b0; m_lc = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        @(negedge clk);

        // reset state
        drive(1, 0, 0, 0, 0);
        check("rst_hit", 32'(hit_count), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);

        // single queued prediction, scored later as a hit
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t1_pending_1", 32'(pending), 32'd1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        check("t1_pending_0", 32'(pending), 32'd0);
        check("t1_hit", 32'(hit_count), 32'd1);
        check("t1_miss", 32'(miss_count), 32'd0);
        check("t1_last_correct", 32'(last_correct), 32'd1);

        // five back-to-back requests overflow a 4-deep buffer
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 1'($urandom_range(0, 1)));
        drive(0, 0, 0, 0, 1'($urandom_range(0, 1)));
        check("t2_pending_full", 32'(pending), 32'd4);
        check("t2_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1'($urandom_range(0, 1)), 0);
        check("t2_pending_empty", 32'(pending), 32'd0);
        check("t2_scored", 32'(hit_count) + 32'(miss_count), 32'd5);

        // result with nothing to score
        drive(0, 0, 1, 1, 0);
        check("t3_underflow", 32'(underflow), 32'd1);
        check("t3_scored", 32'(hit_count) + 32'(miss_count), 32'd5);

        // bypass: result arrives the edge after the request
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 0);
        check("t4_miss", 32'(miss_count), 32'd1);
        check("t4_pending", 32'(pending), 32'd0);
        check("t4_last_correct", 32'(last_correct), 32'd0);

        // request coinciding with result is ignored
        drive(0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        check("t5_pending", 32'(pending), 32'd0);

        // saturation of the 2-bit instance, then reset with entries pending
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 1);
            drive(0, 0, 1, 1, 1);
        end
        check("t6_sat_hit", 32'(s_hit_count), 32'd3);
        check("t6_hit", 32'(hit_count), 32'd5);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        check("t6_pending", 32'(pending), 32'd2);
        drive(1, 0, 0, 0, 0);
        check("t6_rst_pending", 32'(s_pending), 32'd0);
        check("t6_rst_hit", 32'(s_hit_count), 32'd0);
        check("t6_rst_valid", 32'(s_last_valid), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 99) < 55),
                  ($urandom_range(0, 99) < 35),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
